// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit signed add-shift multiplier.
//   mult_state_t : sequencing controller states
//   MULT_N       : operand width, also used by the datapath registers
package mult_pkg;

  localparam int MULT_N = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/mult_control_iter_counter.sv
// Iteration counter for the multiplier controller.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   clr_i      : reload the count to 0
//   inc_i      : advance the count by one
//   last_o     : count is on the final iteration (N-1)
module iter_counter #(
  parameter int N = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  localparam int W = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0] count_q;

  // Never wraps: the controller reloads the count before every run.
  always_ff @(posedge Clk) begin
    if (Reset || clr_i) begin
      count_q <= '0;
    end else if (inc_i) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign last_o = (count_q == W'(N - 1));

endmodule

// File: rtl/mult_control.sv
// Sequencing controller for the signed add-shift multiplier.
// Turns Run / ClearA_LoadB into per-cycle datapath strobes: one add phase
// and one shift phase per multiplier bit, subtracting on the sign bit.
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   Run          : start request (level, synchronized)
//   ClearA_LoadB : load-B / clear-A request (level, synchronized)
//   M            : current multiplier LSB from the B register
//   Clr_Ld       : load B, clear A and X (IDLE only)
//   Clr_XA       : clear A and X at start of a run
//   Add / Sub    : load A/X with A+S / A-S (Mealy on M)
//   Shift        : shift X->A->B right by one
//   Busy / Done  : run in progress / result ready
module mult_control
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_Ld,
  output logic Clr_XA,
  output logic Add,
  output logic Sub,
  output logic Shift,
  output logic Busy,
  output logic Done
);

  mult_state_t state_q, state_d;
  logic        arm_q;
  logic        cnt_clr, cnt_inc, cnt_last;

  iter_counter #(.N(N)) u_iter (
    .Clk    (Clk),
    .Reset  (Reset),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .last_o (cnt_last)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Arm only after Run has been seen low in IDLE, so a Run level that is
  // still held from the previous run (or across a reset) cannot restart.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      arm_q <= 1'b0;
    end else if (state_q == IDLE && state_d == IDLE) begin
      arm_q <= arm_q | ~Run;
    end else begin
      arm_q <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    Clr_Ld  = 1'b0;
    Clr_XA  = 1'b0;
    Add     = 1'b0;
    Sub     = 1'b0;
    Shift   = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Run && arm_q) begin
          state_d = CLEAR;
        end else begin
          // Suppressed during the reset cycle so no load races the reset.
          Clr_Ld = ClearA_LoadB & ~Reset;
        end
      end
      CLEAR: begin
        Clr_XA  = 1'b1;
        Busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        // The final multiplier bit carries negative weight.
        if (cnt_last) begin
          Sub = M;
        end else begin
          Add = M;
        end
        state_d = SHIFT;
      end
      SHIFT: begin
        Busy  = 1'b1;
        Shift = 1'b1;
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = ADD;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
module tb_mult_control;

  logic Clk = 1'b0;
  logic Reset, Run, ClearA_LoadB, M;
  logic Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done;

  int vectors = 0;
  int miscompares = 0;

  mult_control dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_Ld       (Clr_Ld),
    .Clr_XA       (Clr_XA),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  // Expected vector bit order: {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done}
  localparam logic [6:0] E_IDLE  = 7'b0000000;
  localparam logic [6:0] E_LD    = 7'b1000000;
  localparam logic [6:0] E_CLEAR = 7'b0100010;
  localparam logic [6:0] E_ADD0  = 7'b0000010;
  localparam logic [6:0] E_ADD   = 7'b0010010;
  localparam logic [6:0] E_SUB   = 7'b0001010;
  localparam logic [6:0] E_SHIFT = 7'b0000110;
  localparam logic [6:0] E_DONE  = 7'b0000001;

  // Called at a falling edge: drive inputs, check outputs for this cycle,
  // then advance to the next falling edge.
  task automatic cyc(input logic run, input logic clab, input logic m,
                     input logic rst, input logic [6:0] exp, input string tag);
    logic [6:0] obs;
    Run = run; ClearA_LoadB = clab; M = m; Reset = rst;
    #1;
    obs = {Clr_Ld, Clr_XA, Add, Sub, Shift, Busy, Done};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
    vectors++;
    assert ($countones(obs[6:2]) <= 1) else begin
      miscompares++;
      $error("FAIL %s_onehot: observed strobes %b required at most one high", tag, obs[6:2]);
    end
    @(negedge Clk);
  endtask

  // Accept cycle, CLEAR, 8 ADD/SHIFT pairs, DONE. abort_shift >= 0 applies
  // Reset during that SHIFT (0-based) and returns.
  task automatic do_run(input logic [7:0] mbits, input logic run_hold,
                        input logic clab, input int abort_shift, input string tag);
    int cnum;
    logic [6:0] e;
    cyc(1'b1, clab, 1'b0, 1'b0, E_IDLE, {tag, "_accept"});
    cnum = 1;
    cyc(run_hold, clab, 1'b0, 1'b0, E_CLEAR, {tag, "_clear"});
    for (int i = 0; i < 8; i++) begin
      cnum++;
      if (!mbits[i])   e = E_ADD0;
      else if (i < 7)  e = E_ADD;
      else             e = E_SUB;
      cyc(run_hold, clab, mbits[i], 1'b0, e, $sformatf("%s_add%0d", tag, i));
      cnum++;
      if (i == abort_shift) begin
        cyc(run_hold, clab, 1'b0, 1'b1, E_SHIFT, $sformatf("%s_rstshift%0d", tag, i));
        $display("run %s: B=%h reset during shift %0d", tag, mbits, i);
        return;
      end
      cyc(run_hold, clab, 1'b0, 1'b0, E_SHIFT, $sformatf("%s_shift%0d", tag, i));
    end
    cnum++;
    vectors++;
    assert (cnum === 18) else begin
      miscompares++;
      $error("FAIL %s_latency: observed %0d required 18", tag, cnum);
    end
    cyc(run_hold, clab, 1'b0, 1'b0, E_DONE, {tag, "_done"});
    $display("run %s: B=%h done at cycle %0d", tag, mbits, cnum);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;
    @(negedge Clk);

    // Reset cycle: Clr_Ld held off even with ClearA_LoadB high.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, E_IDLE, "reset");
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b0, 1'b0, E_LD, $sformatf("clrld%0d", k));
    cyc(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "idle");
    $display("load: Clr_Ld pulsed for 3 cycles");

    // B = 0xCD, Run pulsed then released: DONE exits straight to IDLE.
    do_run(8'hCD, 1'b0, 1'b0, -1, "cd");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "cd_idle");

    // B = 0, Run held: DONE persists, no restart.
    do_run(8'h00, 1'b1, 1'b0, -1, "zero");
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, E_DONE, $sformatf("zero_hold%0d", k));

    // Run low one cycle in DONE, then high again in IDLE: not armed.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, E_DONE, "rel_done");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "rel_idle0");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, E_LD,   "rel_idle1");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "rel_idle2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "rel_arm");
    $display("rearm: held Run ignored until released");

    // Re-armed run, aborted by Reset during the 4th SHIFT with Run held.
    do_run(8'hA5, 1'b1, 1'b0, 3, "abort");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "abort_idle0");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, E_IDLE, "abort_idle1");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, E_LD,   "abort_idle2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, E_IDLE, "abort_arm");

    // Run and ClearA_LoadB together: Run wins; ClearA_LoadB ignored mid-run.
    do_run(8'h80, 1'b0, 1'b1, -1, "prio");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, E_LD, "prio_idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of run required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mult_control.md
# mult_control

Sequencing controller for the 8-bit signed add-shift multiplier. It sits directly upstream of the A and B shift registers and the 9-bit adder/subtractor. It turns the Run and ClearA_LoadB switch inputs into per-cycle Clr_Ld, Clr_XA, Add, Sub and Shift strobes, one add phase and one shift phase per multiplier bit, and reports Busy/Done to the top level.

## Interface
- N, default 8: operand width; number of add/shift iterations.
- Clk  input  1  system clock, all state updates on rising edge.
- Reset  input  1  synchronous, active-high.
- Run  input  1  start request, level; already synchronized upstream.
- ClearA_LoadB  input  1  load-B/clear-A request, level; already synchronized upstream.
- M  input  1  current multiplier LSB (B register Shift_Out).
- Clr_Ld  output  1  load B from switches; clear A and X.
- Clr_XA  output  1  clear A and X at start of a run; B untouched.
- Add  output  1  load A/X with A+S (sign-extended to 9 bits).
- Sub  output  1  load A/X with A−S (final iteration only).
- Shift  output  1  shift X→A→B right by one, with arithmetic fill from X.
- Busy  output  1  high from the CLEAR state through the last SHIFT state.
- Done  output  1  high in the DONE state.

## Operation
- States: IDLE, CLEAR, ADD, SHIFT, DONE.
- Arm flag:
  - Reset value 0.
  - Set in IDLE when Run=0.
  - Cleared on leaving IDLE.
  - Run is accepted only while armed. A held Run never restarts the block.
- IDLE:
  - Run=1 and armed → CLEAR.
  - Otherwise Clr_Ld = ClearA_LoadB (level, repeats every cycle).
  - Run has priority: if it is accepted, Clr_Ld=0 that cycle.
- CLEAR: Clr_XA=1 for exactly one cycle. Iteration counter i←0. → ADD.
- ADD:
  - If i<N−1: Add = M.
  - If i=N−1: Sub = M.
  - If M=0: no strobe.
  - Next state → SHIFT.
- SHIFT:
  - Shift=1 for one cycle.
  - If i=N−1 → DONE; otherwise i←i+1 → ADD.
- DONE: all strobes 0 and Done=1. Stays while Run=1; Run=0 → IDLE (arm set next cycle).
- Strobe exclusivity: at most one of Clr_Ld, Clr_XA, Add, Sub, Shift is high in any cycle.
- Add and Sub are Mealy outputs (depend on M combinationally). All other outputs decode from state only.
- ClearA_LoadB is ignored outside IDLE.
- Counter width $clog2(N); no wrap is used, because the counter is reloaded to 0 in CLEAR.

## Timing
- Reset (any state, including mid-run):
  - Next edge forces IDLE, i=0, arm=0.
  - All outputs 0 except Clr_Ld, which follows ClearA_LoadB once arm logic allows IDLE decode.
  - Clr_Ld is 0 during the Reset cycle itself.
- Latency from the Run accept edge:
  - CLEAR occupies cycle 1.
  - ADD/SHIFT pairs occupy cycles 2..2N+1.
  - Done rises at cycle 2N+2 (18 for N=8).
- M is sampled in the ADD cycle. It must be stable one cycle after the preceding Shift (B register output).
- Busy = state ∈ {CLEAR, ADD, SHIFT}.
- Run dropping mid-run has no effect. Release is only observed in DONE.

## Structure
- Package mult_pkg:
  - mult_state_t enum (IDLE, CLEAR, ADD, SHIFT, DONE).
  - Localparam MULT_N = 8, shared with the datapath registers.
- One sub-module, iter_counter:
  - Clear, increment enable, terminal flag (i = N−1).
  - Parameterized by N.
- Controller body: one state register, one always_comb next-state/output block, and the arm flip-flop.

## Test plan
- Reset, then ClearA_LoadB=1 for 3 cycles in IDLE → Clr_Ld high exactly those 3 cycles; no other strobe.
- Run pulse with M stream 1,0,1,1,0,0,1,1 (B=0xCD) →
  - Clr_XA at cycle 1.
  - Add at ADD cycles for i=0,2,3,6.
  - Sub at i=7.
  - 8 Shift pulses.
  - Done at cycle 18.
- M=0 for all 8 bits → no Add/Sub, 8 Shift pulses, Done at cycle 18. Run held high 10 extra cycles → stays DONE, no restart.
- Run held high across DONE→IDLE → no second run until Run=0 for ≥1 cycle, then Run=1 → CLEAR next cycle.
- Reset asserted during the 4th SHIFT → IDLE next edge, Busy=0, all strobes 0. Run already high at that point → ignored until Run goes low.
- Run and ClearA_LoadB both high while armed in IDLE → CLEAR entered, Clr_Ld=0 that cycle. Check strobe one-hot/zero assertion on every cycle of all tests.
